// File: rtl/dec_pkg.sv
// Shared constants and helpers for the decoder/scanner block.
package dec_pkg;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/dec_scan_if.sv
// Bus between the dec_scan block and its controller: selects in, decoded lines out.
interface dec_scan_if #(
  parameter int unsigned N = 2
);
  logic              EN;
  logic              MODE;
  logic [N-1:0]      IN;
  logic [2**N-1:0]   OUT;
  logic [N-1:0]      SEL;
  logic              WRAP;

  modport master (
    output EN,
    output MODE,
    output IN,
    input  OUT,
    input  SEL,
    input  WRAP
  );

  modport slave (
    input  EN,
    input  MODE,
    input  IN,
    output OUT,
    output SEL,
    output WRAP
  );
endinterface

// File: rtl/dec_onehot.sv
// Combinational N-to-2**N one-hot expander, all-zero when disabled.
module dec_onehot #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]    IN,
  input  logic            EN,
  output logic [2**N-1:0] OUT
);

  always_comb begin
    OUT = '0;
    if (EN) begin
      OUT[IN] = 1'b1;
    end
  end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with an auto-scan mode driven by a DIV-cycle prescaler.
module dec_scan
  import dec_pkg::*;
#(
  parameter int unsigned N   = 2,
  parameter int unsigned DIV = 4
) (
  input logic       CLK,
  input logic       RST,
  dec_scan_if.slave bus
);

  localparam int unsigned M       = 2 ** N;
  localparam int unsigned PW      = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] PreLast = PW'(DIV - 1);

  logic [N-1:0]  sel_d, sel_q;
  logic [PW-1:0] pre_d, pre_q;
  logic          wrap_d, wrap_q;
  logic          mode_d, mode_q;
  logic [M-1:0]  out_d, out_q;

  // mode_q holds the mode seen on the last enabled edge, so a scan entered from
  // decode (or from reset) reloads from IN while a paused scan resumes in place.
  always_comb begin
    sel_d  = sel_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    mode_d = mode_q;
    if (bus.EN) begin
      mode_d = bus.MODE;
      if (bus.MODE == MODE_DECODE || mode_q == MODE_DECODE) begin
        sel_d = bus.IN;
        pre_d = '0;
      end else if (pre_q == PreLast) begin
        pre_d  = '0;
        sel_d  = sel_q + N'(1);
        wrap_d = &sel_q;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  dec_onehot #(
    .N(N)
  ) u_onehot (
    .IN (sel_d),
    .EN (bus.EN),
    .OUT(out_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
      mode_q <= MODE_DECODE;
      out_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
      out_q  <= out_d;
    end
  end

  assign bus.OUT  = out_q;
  assign bus.SEL  = sel_q;
  assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Bench for dec_scan: two instances (N=2/DIV=4 and N=3/DIV=1) against an integer model.
module tb_dec_scan;

  logic clk;
  logic rst;

  dec_scan_if #(.N(2)) if0 ();
  dec_scan_if #(.N(3)) if1 ();

  dec_scan #(
    .N  (2),
    .DIV(4)
  ) u_dut0 (
    .CLK(clk),
    .RST(rst),
    .bus(if0)
  );

  dec_scan #(
    .N  (3),
    .DIV(1)
  ) u_dut1 (
    .CLK(clk),
    .RST(rst),
    .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference state: selected index, prescaler count, whether a scan is in progress.
  int mv[2] = '{4, 8};
  int dv[2] = '{4, 1};
  int m_sel[2];
  int m_pre[2];
  int m_scan[2];
  int e_out[2];
  int e_wrap[2];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    assert (obs === 32'(exp))
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int d, input logic r, input logic e, input logic md, input int in);
    if (r) begin
      m_sel[d] = 0; m_pre[d] = 0; m_scan[d] = 0; e_out[d] = 0; e_wrap[d] = 0;
    end else if (!e) begin
      e_out[d] = 0; e_wrap[d] = 0;
    end else if (!md) begin
      m_sel[d] = in; m_pre[d] = 0; m_scan[d] = 0; e_wrap[d] = 0;
      e_out[d] = 1 << in;
    end else if (m_scan[d] == 0) begin
      m_sel[d] = in; m_pre[d] = 0; m_scan[d] = 1; e_wrap[d] = 0;
      e_out[d] = 1 << in;
    end else begin
      e_wrap[d] = 0;
      if (m_pre[d] == dv[d] - 1) begin
        m_pre[d] = 0;
        if (m_sel[d] == mv[d] - 1) e_wrap[d] = 1;
        m_sel[d] = (m_sel[d] + 1) % mv[d];
      end else begin
        m_pre[d] = m_pre[d] + 1;
      end
      e_out[d] = 1 << m_sel[d];
    end
  endtask

  task automatic step(input logic r, input logic e, input logic md, input int in0, input int in1);
    rst      = r;
    if0.EN   = e;
    if0.MODE = md;
    if0.IN   = 2'(in0);
    if1.EN   = e;
    if1.MODE = md;
    if1.IN   = 3'(in1);
    @(posedge clk);
    model(0, r, e, md, in0);
    model(1, r, e, md, in1);
    #1;
    chk("d0_out", 32'(if0.OUT), e_out[0]);
    chk("d0_sel", 32'(if0.SEL), m_sel[0]);
    chk("d0_wrap", 32'(if0.WRAP), e_wrap[0]);
    chk("d1_out", 32'(if1.OUT), e_out[1]);
    chk("d1_sel", 32'(if1.SEL), m_sel[1]);
    chk("d1_wrap", 32'(if1.WRAP), e_wrap[1]);
    chk("d0_onehot", 32'($countones(if0.OUT) <= 1), 1);
    chk("d1_onehot", 32'($countones(if1.OUT) <= 1), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic md;
    int   wraps1;

    // Reset state
    step(1'b1, 1'b1, 1'b1, 3, 7);
    chk("reset_out", 32'(if0.OUT), 0);
    chk("reset_sel", 32'(if0.SEL), 0);

    // Decode sweep
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, i, 7 - i);
      chk("decode_out", 32'(if0.OUT), 1 << i);
      chk("decode_wrap", 32'(if0.WRAP), 0);
    end

    // Disable: outputs clear, SEL holds 3
    step(1'b0, 1'b0, 1'b1, 2, 2);
    chk("disable_out", 32'(if0.OUT), 0);
    chk("disable_sel_hold", 32'(if0.SEL), 3);
    step(1'b0, 1'b0, 1'b0, 2, 2);
    chk("disable_sel_hold2", 32'(if0.SEL), 3);

    // Scan from IN=1 (dut0, DIV=4) and IN=0 (dut1, DIV=1)
    wraps1 = 0;
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 1'b1, 1'b1, 1, 0);
      chk("scan_sel_seq", 32'(if0.SEL), (1 + k / 4) % 4);
      chk("scan_wrap_seq", 32'(if0.WRAP), (k == 12) ? 1 : 0);
      chk("walk_out", 32'(if1.OUT), 1 << (k % 8));
      chk("walk_wrap", 32'(if1.WRAP), (k > 0 && k % 8 == 0) ? 1 : 0);
      wraps1 += int'(if1.WRAP);
    end
    chk("walk_wrap_count", 32'(wraps1), 2);

    // Pause at SEL=2, prescaler=1
    for (int g = 0; g < 32 && !(m_sel[0] == 2 && m_pre[0] == 1); g++) begin
      step(1'b0, 1'b1, 1'b1, 0, 0);
    end
    chk("pause_point_sel", 32'(if0.SEL), 2);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 0, 0);
      chk("paused_sel", 32'(if0.SEL), 2);
      chk("paused_out", 32'(if0.OUT), 0);
    end
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 0, 0);
      chk("resume_sel", 32'(if0.SEL), (k == 3) ? 3 : 2);
    end

    // Reset mid-scan at SEL=3, then restart from IN
    for (int g = 0; g < 32 && m_sel[0] != 3; g++) begin
      step(1'b0, 1'b1, 1'b1, 0, 0);
    end
    step(1'b1, 1'b1, 1'b1, 0, 0);
    chk("midreset_out", 32'(if0.OUT), 0);
    chk("midreset_sel", 32'(if0.SEL), 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b1, 2, 5);
      chk("restart_sel", 32'(if0.SEL), (k < 4) ? 2 : 3);
      if (k == 0) chk("restart_d1_out", 32'(if1.OUT), 32);
    end

    // Random traffic; mode only changes on enabled edges
    md = 1'b1;
    for (int k = 0; k < 400; k++) begin
      logic r;
      logic e;
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 99) < 85);
      if (e && $urandom_range(0, 9) == 0) md = ~md;
      step(r, e, md, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
